// File: rtl/laser_controller.sv
// Per-tower laser sequencer. It steps the laser datapath through draw, hold, erase and
// cooldown, and requests the shared VGA write port for the draw and erase phases.
module laser_controller #(
    parameter int            CW              = 25,
    parameter logic [CW-1:0] COOLDOWN_CYCLES = 25'd8_333_333
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tower_placed,
    input  logic       game_over,
    input  logic       car_in_range,
    input  logic       draw_done,
    input  logic       delay_done,
    input  logic       erase_done,
    input  logic       vga_grant,
    output logic       disabled,
    output logic       wait_draw,
    output logic       draw_laser,
    output logic       delay,
    output logic       erase,
    output logic       vga_req,
    output logic       plot,
    output logic       busy,
    output logic [7:0] shots,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_WAIT      = 3'd1,
        S_REQ_DRAW  = 3'd2,
        S_DRAW      = 3'd3,
        S_HOLD      = 3'd4,
        S_REQ_ERASE = 3'd5,
        S_ERASE     = 3'd6,
        S_COOL      = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_pend_q, abort_pend_d;
    logic [7:0]    shots_q, shots_d;
    logic          abort;

    assign abort = game_over | ~tower_placed;

    always_comb begin
        state_d      = state_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            S_OFF:       if (tower_placed && !game_over) state_d = S_WAIT;
            S_WAIT:      if (abort) state_d = S_OFF;
                         else if (car_in_range) state_d = S_REQ_DRAW;
            S_REQ_DRAW:  if (abort) state_d = S_OFF;
                         else if (vga_grant) state_d = S_DRAW;
            // Anything already on screen must be erased, so an abort here still erases.
            S_DRAW: begin
                if (abort) begin
                    state_d      = S_REQ_ERASE;
                    abort_pend_d = 1'b1;
                end else if (draw_done) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d      = S_REQ_ERASE;
                    abort_pend_d = 1'b1;
                end else if (delay_done) begin
                    state_d = S_REQ_ERASE;
                end
            end
            S_REQ_ERASE: begin
                if (abort) abort_pend_d = 1'b1;
                if (vga_grant) state_d = S_ERASE;
            end
            S_ERASE: begin
                if (abort) abort_pend_d = 1'b1;
                if (erase_done) state_d = (abort_pend_q || abort) ? S_OFF : S_COOL;
            end
            S_COOL:      if (abort) state_d = S_OFF;
                         else if (cnt_q == '0) state_d = S_WAIT;
            default:     state_d = S_OFF;
        endcase
        if (state_d == S_OFF) abort_pend_d = 1'b0;
    end

    // Counter is loaded with N-1 on entry so COOL spans exactly N cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_COOL && state_d == S_COOL) cnt_d = COOLDOWN_CYCLES - 1'b1;
        else if (state_q == S_COOL && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        shots_d = shots_q;
        if (state_q == S_REQ_DRAW && state_d == S_DRAW && shots_q != 8'hFF)
            shots_d = shots_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            shots_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_pend_q <= abort_pend_d;
            shots_q      <= shots_d;
        end
    end

    always_comb begin
        disabled   = 1'b0;
        wait_draw  = 1'b0;
        draw_laser = 1'b0;
        delay      = 1'b0;
        erase      = 1'b0;
        vga_req    = 1'b0;
        case (state_q)
            S_OFF:       disabled = 1'b1;
            S_WAIT:      wait_draw = 1'b1;
            S_REQ_DRAW:  begin wait_draw = 1'b1;  vga_req = 1'b1; end
            S_DRAW:      begin draw_laser = 1'b1; vga_req = 1'b1; end
            S_HOLD:      delay = 1'b1;
            S_REQ_ERASE: vga_req = 1'b1;
            S_ERASE:     begin erase = 1'b1;      vga_req = 1'b1; end
            default:     ;
        endcase
    end

    assign plot      = (draw_laser | erase) & vga_grant;
    assign busy      = (state_q != S_OFF) && (state_q != S_WAIT);
    assign shots     = shots_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_laser_controller.sv
// Directed bench for laser_controller with a short cooldown; each step compares the
// output strobes and shot count against hand-derived values.
module tb_laser_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tower_placed, game_over, car_in_range;
    logic       draw_done, delay_done, erase_done, vga_grant;
    logic       disabled, wait_draw, draw_laser, delay, erase, vga_req, plot, busy;
    logic [7:0] shots;
    logic [2:0] state_dbg;

    int vectors    = 0;
    int miscompares = 0;

    // Output vector bit order: disabled wait_draw draw_laser delay erase vga_req plot busy
    localparam logic [7:0] O_OFF     = 8'b1000_0000;
    localparam logic [7:0] O_WAIT    = 8'b0100_0000;
    localparam logic [7:0] O_REQD    = 8'b0100_0101;
    localparam logic [7:0] O_DRAW_G  = 8'b0010_0111;
    localparam logic [7:0] O_HOLD    = 8'b0001_0001;
    localparam logic [7:0] O_REQE    = 8'b0000_0101;
    localparam logic [7:0] O_ERASE_G = 8'b0000_1111;
    localparam logic [7:0] O_COOL    = 8'b0000_0001;

    laser_controller #(.CW(25), .COOLDOWN_CYCLES(25'd4)) dut (
        .clk(clk), .resetn(resetn),
        .tower_placed(tower_placed), .game_over(game_over), .car_in_range(car_in_range),
        .draw_done(draw_done), .delay_done(delay_done), .erase_done(erase_done),
        .vga_grant(vga_grant),
        .disabled(disabled), .wait_draw(wait_draw), .draw_laser(draw_laser), .delay(delay),
        .erase(erase), .vga_req(vga_req), .plot(plot), .busy(busy), .shots(shots),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {disabled, wait_draw, draw_laser, delay, erase, vga_req, plot, busy};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s outs=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_shots(input string tag, input logic [7:0] exp);
        vectors++;
        assert (shots === exp) else begin
            miscompares++;
            $error("FAIL %s shots=%0d expected=%0d", tag, shots, exp);
        end
    endtask

    task automatic full_shot();
        car_in_range = 1'b1; step();
        car_in_range = 1'b0; vga_grant = 1'b1; step();
        draw_done = 1'b1; step();
        draw_done = 1'b0; vga_grant = 1'b0; delay_done = 1'b1; step();
        delay_done = 1'b0; vga_grant = 1'b1; step();
        erase_done = 1'b1; step();
        erase_done = 1'b0; vga_grant = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        resetn = 1'b0; tower_placed = 1'b0; game_over = 1'b0; car_in_range = 1'b0;
        draw_done = 1'b0; delay_done = 1'b0; erase_done = 1'b0; vga_grant = 1'b0;
        step(); step();
        check_outs("reset_outs", O_OFF);
        check_shots("reset_shots", 8'd0);
        resetn = 1'b1;
        step();
        check_outs("off_idle", O_OFF);

        tower_placed = 1'b1; step();
        check_outs("to_wait", O_WAIT);
        tower_placed = 1'b0; step();
        check_outs("wait_abort_off", O_OFF);
        tower_placed = 1'b1; step();
        check_outs("rewait", O_WAIT);

        // First shot with immediate grant, then the full phase sequence
        car_in_range = 1'b1; step();
        check_outs("req_draw", O_REQD);
        car_in_range = 1'b0; vga_grant = 1'b1; step();
        check_outs("draw_2cyc", O_DRAW_G);
        check_shots("shots_1", 8'd1);
        delay_done = 1'b1; step();
        check_outs("draw_ignores_delay_done", O_DRAW_G);
        delay_done = 1'b0; draw_done = 1'b1; step();
        check_outs("hold", O_HOLD);
        draw_done = 1'b0; vga_grant = 1'b0; step();
        check_outs("hold_stay", O_HOLD);
        delay_done = 1'b1; step();
        check_outs("req_erase", O_REQE);
        delay_done = 1'b0; step();
        check_outs("req_erase_wait", O_REQE);
        vga_grant = 1'b1; step();
        check_outs("erase", O_ERASE_G);
        erase_done = 1'b1; step();
        check_outs("cool_1", O_COOL);
        erase_done = 1'b0; vga_grant = 1'b0; draw_done = 1'b1; step();
        check_outs("cool_2", O_COOL);
        draw_done = 1'b0; step();
        check_outs("cool_3", O_COOL);
        step();
        check_outs("cool_4", O_COOL);
        step();
        check_outs("cool_exit_wait", O_WAIT);

        // Grant withheld for 10 cycles in REQ_DRAW
        car_in_range = 1'b1; step();
        car_in_range = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_outs($sformatf("no_grant_%0d", i), O_REQD);
            step();
        end
        check_outs("no_grant_end", O_REQD);
        check_shots("shots_held", 8'd1);
        vga_grant = 1'b1; step();
        check_outs("late_draw", O_DRAW_G);
        check_shots("shots_2", 8'd2);

        // game_over pulse in HOLD: erase runs, then OFF without COOL
        draw_done = 1'b1; step();
        draw_done = 1'b0; vga_grant = 1'b0; game_over = 1'b1; step();
        check_outs("go_hold_req_erase", O_REQE);
        game_over = 1'b0; vga_grant = 1'b1; step();
        check_outs("go_erase", O_ERASE_G);
        erase_done = 1'b1; step();
        check_outs("go_off", O_OFF);
        erase_done = 1'b0; vga_grant = 1'b0; step();
        check_outs("go_rewait", O_WAIT);

        // game_over with draw_done in DRAW, then reset in ERASE
        car_in_range = 1'b1; step();
        car_in_range = 1'b0; vga_grant = 1'b1; step();
        check_shots("shots_3", 8'd3);
        game_over = 1'b1; draw_done = 1'b1; step();
        check_outs("go_draw_done_req_erase", O_REQE);
        draw_done = 1'b0; step();
        check_outs("go_erase_2", O_ERASE_G);
        resetn = 1'b0; #1;
        check_outs("async_reset_off", O_OFF);
        check_shots("async_reset_shots", 8'd0);
        step();
        resetn = 1'b1; game_over = 1'b0; vga_grant = 1'b0; step();
        check_outs("post_reset_wait", O_WAIT);

        // Saturation of the shot counter
        for (int i = 0; i < 200; i++) full_shot();
        check_outs("loop_wait", O_WAIT);
        check_shots("shots_200", 8'd200);
        for (int i = 0; i < 60; i++) full_shot();
        check_outs("loop_wait_end", O_WAIT);
        check_shots("shots_sat", 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/laser_controller.md
# laser_controller

Moore FSM that sequences one tower's laser datapath through fire, hold, erase and cooldown phases. It arbitrates for the shared VGA write port on behalf of that datapath. It sits between the tower-placement/game logic and the laser datapath. It drives the datapath's mode strobes and consumes the datapath's done flags. One instance exists per tower; a separate round-robin arbiter owns `vga_grant`.

## Interface

Parameters:
- `COOLDOWN_CYCLES`, default 25'd8_333_333: cycles spent in COOL between shots; 1/6 s at 50 MHz; legal range 1..2^25-1.
- `CW`, default 25: width of the cooldown counter.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `resetn`  in  1  asynchronous, active-low reset.
- `tower_placed`  in  1  level; tower exists and may fire.
- `game_over`  in  1  level; forces the controller toward OFF.
- `car_in_range`  in  1  level from datapath; a target is in range.
- `draw_done`  in  1  pulse from datapath; laser line fully drawn.
- `delay_done`  in  1  pulse from datapath; on-screen hold elapsed.
- `erase_done`  in  1  pulse from datapath; laser line fully erased.
- `vga_grant`  in  1  arbiter grant; held high by the arbiter while `vga_req` stays high.
- `disabled`, `wait_draw`, `draw_laser`, `delay`, `erase`  out  1 each  datapath mode strobes.
- `vga_req`  out  1  request for the shared VGA write port.
- `plot`  out  1  VGA write enable for the datapath pixel.
- `busy`  out  1  high in any state other than OFF and WAIT.
- `shots`  out  8  saturating count of shots fired.

## Operation

- States: OFF, WAIT, REQ_DRAW, DRAW, HOLD, REQ_ERASE, ERASE, COOL.
- Outputs decode from the state register only (Moore). Exceptions: `plot`, and `shots` as a separate register.
- Output decode per state:
  - OFF: `disabled`=1.
  - WAIT: `wait_draw`=1.
  - REQ_DRAW: `wait_draw`=1, `vga_req`=1.
  - DRAW: `draw_laser`=1, `vga_req`=1.
  - HOLD: `delay`=1.
  - REQ_ERASE: `vga_req`=1; all strobes low.
  - ERASE: `erase`=1, `vga_req`=1.
  - COOL: all strobes low.
- `plot` = (`draw_laser` | `erase`) & `vga_grant`.
- Normal transitions:
  - OFF -> WAIT when `tower_placed` & !`game_over`.
  - WAIT -> REQ_DRAW when `car_in_range`.
  - REQ_DRAW -> DRAW when `vga_grant`.
  - DRAW -> HOLD on `draw_done`.
  - HOLD -> REQ_ERASE on `delay_done`.
  - REQ_ERASE -> ERASE on `vga_grant`.
  - ERASE -> COOL on `erase_done`.
  - COOL -> WAIT when the counter reaches 0.
- Abort condition: `abort` = `game_over` | !`tower_placed`.
  - In WAIT, REQ_DRAW or COOL: abort goes to OFF next cycle.
  - In DRAW or HOLD: abort sets the `abort_pend` flag and goes to REQ_ERASE next cycle, so partially drawn pixels are always erased.
  - In REQ_ERASE or ERASE: abort sets `abort_pend`; the erase runs to completion.
  - ERASE exit with `abort_pend`=1 goes to OFF, not COOL; `abort_pend` clears on entry to OFF.
- Priority order: abort over any normal transition, except the erase-completion path described above.
- If `draw_done` and abort arrive in the same cycle in DRAW, the next state is REQ_ERASE.
- Cooldown counter:
  - Loads `COOLDOWN_CYCLES`-1 on entry to COOL and decrements each cycle in COOL.
  - Exits when the counter equals 0, so COOL lasts exactly `COOLDOWN_CYCLES` cycles.
  - Unsigned; never wraps because exit occurs at 0.
- `shots`:
  - Increments on each REQ_DRAW -> DRAW transition.
  - Saturates at 255.
  - Cleared only by `resetn`; survives OFF.
- Done pulses arriving in a state that does not consume them are ignored.
- `vga_grant` asserted while `vga_req`=0 is ignored.

## Timing

- Reset: asynchronous, active-low. While `resetn`=0 and on its release:
  - State is OFF and `disabled`=1.
  - All other strobes, `vga_req`, `plot` and `busy` are 0.
  - `shots`=0, the cooldown counter is 0, and `abort_pend`=0.
- Reset asserted mid-operation forces OFF immediately, with no erase. The datapath's own reset clears its state.
- All transitions occur on the rising edge of `clk`. Outputs change in the same cycle as the state register.
- Minimum latencies:
  - `car_in_range` sampled in WAIT to `draw_laser`=1 is 2 cycles, with `vga_grant` arriving the cycle after `vga_req` rises.
  - `erase_done` to the return of `wait_draw` is `COOLDOWN_CYCLES`+1 cycles.
- `vga_req` stays high continuously from REQ_DRAW through DRAW. It drops in HOLD and re-asserts in REQ_ERASE.
- The arbiter may withhold `vga_grant` indefinitely. The controller waits with no timeout, and `plot` stays 0 while the grant is low.

## Test plan

- Reset, then `tower_placed`=1 -> WAIT one cycle later. `car_in_range`=1 with grant on the next cycle -> `draw_laser`=1 two cycles after WAIT samples `car_in_range`, and `shots`=1.
- Full shot with `COOLDOWN_CYCLES`=4: pulse `draw_done`, then `delay_done`, grant, then `erase_done` -> state sequence DRAW, HOLD, REQ_ERASE, ERASE, then COOL for exactly 4 cycles, then WAIT.
- Grant withheld 10 cycles in REQ_DRAW -> `vga_req`=1, `plot`=0 and `wait_draw`=1 throughout; DRAW follows 1 cycle after grant.
- `game_over` pulsed in HOLD -> REQ_ERASE, then ERASE; `erase_done` -> OFF (`disabled`=1), with no COOL.
- `game_over` and `draw_done` in the same DRAW cycle -> REQ_ERASE; `resetn` asserted mid-ERASE -> `disabled`=1 immediately and `shots`=0.
- 260 complete shots -> `shots` saturates at 255.
